// File: rtl/sha256_kt_seq.sv
// sha256_kt_seq
// Walks the SHA-256 Kt constant BRAM once per 512-bit block: 7 leading zero
// slots, K[0..63], one trailing zero slot (72 reads per block). Blocks
// are issued back-to-back without bubbles. Round tags (valid, index, first,
// last, block index, done) are sent through a register delay line matching
// the BRAM read latency, so they line up with Kt at the BRAM output.
//
// Ports:
//   CLK        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request, accepted when start & ready
//   n_blk      in   [3:0] number of blocks (0 treated as 1), sampled at accept
//   ready      out  high only while idle
//   kt_en      out  BRAM read enable
//   kt_t       out  [6:0] BRAM read address 0..71
//   kt_wr_en   out  BRAM dummy write enable, tied low
//   kt_wr_addr out  BRAM dummy write address, tied low
//   rnd_valid  out  Kt at BRAM output is K[rnd]
//   rnd        out  [5:0] round index
//   rnd_first  out  round 0 strobe
//   rnd_last   out  round 63 strobe
//   blk_idx    out  [3:0] block index of the current round
//   done       out  pulse with rnd_last of the final block
module sha256_kt_seq #(
   parameter int N_SLOTS   = 72,
   parameter int PRE_SLOTS = 7,
   parameter int RD_LAT    = 2
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] n_blk,
   output logic       ready,
   output logic       kt_en,
   output logic [6:0] kt_t,
   output logic       kt_wr_en,
   output logic       kt_wr_addr,
   output logic       rnd_valid,
   output logic [5:0] rnd,
   output logic       rnd_first,
   output logic       rnd_last,
   output logic [3:0] blk_idx,
   output logic       done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [6:0] T_LAST   = 7'(N_SLOTS - 1);
   localparam logic [6:0] T_FIRST  = 7'(PRE_SLOTS);
   localparam logic [6:0] T_KLAST  = 7'(PRE_SLOTS + 63);

   localparam int         DCW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [DCW-1:0] D_LAST = DCW'(RD_LAT - 1);

   // tag layout: {valid, first, last, done, rnd[5:0], blk[3:0]}
   localparam int TAG_W = 14;

   logic [1:0]       state_r,       state_s;
   logic             ready_r,       ready_s;
   logic             kt_en_r,       kt_en_s;
   logic [6:0]       kt_t_r,        kt_t_s;
   logic [3:0]       blk_r,         blk_s;
   logic [3:0]       blocks_left_r, blocks_left_s;
   logic [DCW-1:0]   drain_cnt_r,   drain_cnt_s;

   logic             valid_i_s;
   logic [6:0]       rnd_diff_s;
   logic [5:0]       rnd_i_s;
   logic [3:0]       blk_i_s;
   logic             first_i_s;
   logic             last_i_s;
   logic             done_i_s;
   logic [TAG_W-1:0] tag_i_s;
   logic [TAG_W-1:0] tag_pipe_r [RD_LAT];
   logic [TAG_W-1:0] tag_out_s;

   // Next-state logic for the sequencer FSM and its counters
   always_comb begin
      state_s       = state_r;
      kt_t_s        = kt_t_r;
      blk_s         = blk_r;
      blocks_left_s = blocks_left_r;
      drain_cnt_s   = drain_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s       = ST_RUN;
               kt_t_s        = 7'd0;
               blk_s         = 4'd0;
               blocks_left_s = (n_blk == 4'd0) ? 4'd0 : (n_blk - 4'd1);
            end else begin
               kt_t_s        = 7'd0;
            end
         end
         ST_RUN: begin
            if (kt_t_r == T_LAST) begin
               kt_t_s = 7'd0;
               if (blocks_left_r != 4'd0) begin
                  // next block follows immediately, no bubble
                  blocks_left_s = blocks_left_r - 4'd1;
                  blk_s         = blk_r + 4'd1;
               end else begin
                  state_s     = ST_DRAIN;
                  drain_cnt_s = '0;
               end
            end else begin
               kt_t_s = kt_t_r + 7'd1;
            end
         end
         ST_DRAIN: begin
            // wait out the BRAM latency so the final reads land
            if (drain_cnt_r == D_LAST) begin
               state_s = ST_IDLE;
            end else begin
               drain_cnt_s = drain_cnt_r + DCW'(1);
            end
         end
         default: begin
            state_s = ST_IDLE;
            kt_t_s  = 7'd0;
         end
      endcase
      ready_s = (state_s == ST_IDLE);
      kt_en_s = (state_s == ST_RUN);
   end

   // FSM and address/counter registers
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         ready_r       <= 1'b1;
         kt_en_r       <= 1'b0;
         kt_t_r        <= 7'd0;
         blk_r         <= 4'd0;
         blocks_left_r <= 4'd0;
         drain_cnt_r   <= '0;
      end else begin
         state_r       <= state_s;
         ready_r       <= ready_s;
         kt_en_r       <= kt_en_s;
         kt_t_r        <= kt_t_s;
         blk_r         <= blk_s;
         blocks_left_r <= blocks_left_s;
         drain_cnt_r   <= drain_cnt_s;
      end
   end

   // Issue-side round tags for the address currently driven to the BRAM
   always_comb begin
      valid_i_s  = kt_en_r && (kt_t_r >= T_FIRST) && (kt_t_r <= T_KLAST);
      rnd_diff_s = kt_t_r - T_FIRST;
      // index and block are zeroed off-round so nothing stale leaks out
      if (valid_i_s) begin
         rnd_i_s = rnd_diff_s[5:0];
         blk_i_s = blk_r;
      end else begin
         rnd_i_s = 6'd0;
         blk_i_s = 4'd0;
      end
      first_i_s = valid_i_s && (rnd_i_s == 6'd0);
      last_i_s  = valid_i_s && (rnd_i_s == 6'd63);
      // blocks_left is still 0 at round 63 of the final block
      done_i_s  = last_i_s && (blocks_left_r == 4'd0);
      tag_i_s   = {valid_i_s, first_i_s, last_i_s, done_i_s, rnd_i_s, blk_i_s};
   end

   // Tag delay line matching the BRAM read latency
   always_ff @(posedge CLK) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            tag_pipe_r[i] <= '0;
         end
      end else begin
         tag_pipe_r[0] <= tag_i_s;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_pipe_r[i] <= tag_pipe_r[i-1];
         end
      end
   end

   assign tag_out_s  = tag_pipe_r[RD_LAT-1];

   assign ready      = ready_r;
   assign kt_en      = kt_en_r;
   assign kt_t       = kt_t_r;
   assign kt_wr_en   = 1'b0;
   assign kt_wr_addr = 1'b0;
   assign rnd_valid  = tag_out_s[13];
   assign rnd_first  = tag_out_s[12];
   assign rnd_last   = tag_out_s[11];
   assign done       = tag_out_s[10];
   assign rnd        = tag_out_s[9:4];
   assign blk_idx    = tag_out_s[3:0];

endmodule

// File: tb/tb_sha256_kt_seq.sv
// Directed testbench for sha256_kt_seq. A small 2-cycle-latency ROM model
// driven by kt_en/kt_t provides Kt so its alignment with rnd_valid/rnd can
// be checked against the SHA-256 constant table.
module tb_sha256_kt_seq;

   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] n_blk = 4'd0;
   logic       ready, kt_en, kt_wr_en, kt_wr_addr;
   logic [6:0] kt_t;
   logic       rnd_valid, rnd_first, rnd_last, done;
   logic [5:0] rnd;
   logic [3:0] blk_idx;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic [31:0] rom [72];
   logic [31:0] kt_s1 = 32'd0;
   logic [31:0] kt_q  = 32'd0;

   sha256_kt_seq dut (
      .CLK        (CLK),
      .rst        (rst),
      .start      (start),
      .n_blk      (n_blk),
      .ready      (ready),
      .kt_en      (kt_en),
      .kt_t       (kt_t),
      .kt_wr_en   (kt_wr_en),
      .kt_wr_addr (kt_wr_addr),
      .rnd_valid  (rnd_valid),
      .rnd        (rnd),
      .rnd_first  (rnd_first),
      .rnd_last   (rnd_last),
      .blk_idx    (blk_idx),
      .done       (done)
   );

   always #5 CLK = ~CLK;

   // BRAM model: registered read plus output register
   always @(posedge CLK) begin
      if (kt_en) kt_s1 <= rom[kt_t];
      kt_q <= kt_s1;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      logic [5:0] ob;
      rst = 1'b1; start = 1'b0;
      tick; tick;
      ob = {ready, kt_en, rnd_valid, rnd_first, rnd_last, done};
      n_cmp++;
      if (ob !== 6'b100000) begin
         n_err++; $display("FAIL reset_flags got=%b want=%b", ob, 6'b100000);
      end
      n_cmp++;
      if ({kt_t, rnd, blk_idx, kt_wr_en, kt_wr_addr} !== 19'd0) begin
         n_err++; $display("FAIL reset_values got kt_t=%0d rnd=%0d blk=%0d wr=%b%b want all 0",
                           kt_t, rnd, blk_idx, kt_wr_en, kt_wr_addr);
      end
      rst = 1'b0;
      tick;
   endtask

   // Single block; nb=0 must behave exactly like nb=1
   task automatic test_single(input logic [3:0] nb, input string name);
      logic [5:0] ob, ef;
      n_cmp++;
      if (ready !== 1'b1) begin
         n_err++; $display("FAIL %s ready_c0 got=%b want=1", name, ready);
      end
      start = 1'b1; n_blk = nb;
      tick;
      start = 1'b0; n_blk = 4'd0;
      for (int k = 1; k <= 76; k++) begin
         ob = {ready, kt_en, rnd_valid, rnd_first, rnd_last, done};
         ef = {k >= 75, k <= 72, (k >= 10 && k <= 73), k == 10, k == 73, k == 73};
         n_cmp++;
         if (ob !== ef) begin
            n_err++; $display("FAIL %s flags cyc=%0d got=%b want=%b", name, k, ob, ef);
         end
         if (k <= 72) begin
            n_cmp++;
            if (kt_t !== 7'(k - 1)) begin
               n_err++; $display("FAIL %s kt_t cyc=%0d got=%0d want=%0d", name, k, kt_t, k - 1);
            end
         end
         if (k >= 10 && k <= 73) begin
            n_cmp++;
            if ({rnd, blk_idx} !== {6'(k - 10), 4'd0}) begin
               n_err++; $display("FAIL %s rnd cyc=%0d got=%0d/%0d want=%0d/0", name, k, rnd, blk_idx, k - 10);
            end
            n_cmp++;
            if (kt_q !== K_TAB[k - 10]) begin
               n_err++; $display("FAIL %s kt cyc=%0d got=%h want=%h", name, k, kt_q, K_TAB[k - 10]);
            end
         end
         tick;
      end
   endtask

   task automatic test_back_to_back;
      logic [5:0] ob, ef;
      int m;
      logic vld;
      start = 1'b1; n_blk = 4'd3;
      tick;
      start = 1'b0; n_blk = 4'd0;
      for (int k = 1; k <= 220; k++) begin
         m   = k - 10;
         vld = (m >= 0) && (m < 216) && ((m % 72) < 64);
         ob  = {ready, kt_en, rnd_valid, rnd_first, rnd_last, done};
         ef  = {k >= 219, k <= 216, vld, vld && (m % 72 == 0), vld && (m % 72 == 63), k == 217};
         n_cmp++;
         if (ob !== ef) begin
            n_err++; $display("FAIL b2b flags cyc=%0d got=%b want=%b", k, ob, ef);
         end
         if (k <= 216) begin
            n_cmp++;
            if (kt_t !== 7'((k - 1) % 72)) begin
               n_err++; $display("FAIL b2b kt_t cyc=%0d got=%0d want=%0d", k, kt_t, (k - 1) % 72);
            end
         end
         if (vld) begin
            n_cmp++;
            if ({rnd, blk_idx} !== {6'(m % 72), 4'(m / 72)}) begin
               n_err++; $display("FAIL b2b rnd cyc=%0d got=%0d/%0d want=%0d/%0d", k, rnd, blk_idx, m % 72, m / 72);
            end
            n_cmp++;
            if (kt_q !== K_TAB[m % 72]) begin
               n_err++; $display("FAIL b2b kt cyc=%0d got=%h want=%h", k, kt_q, K_TAB[m % 72]);
            end
         end
         tick;
      end
   endtask

   task automatic test_start_ignored;
      logic [1:0] ob, ef;
      start = 1'b1; n_blk = 4'd1;
      tick;
      n_blk = 4'd2;   // start stays high through RUN and DRAIN
      for (int k = 1; k <= 75; k++) begin
         ob = {ready, kt_en};
         ef = {k >= 75, k <= 72};
         n_cmp++;
         if (ob !== ef) begin
            n_err++; $display("FAIL ignore flags cyc=%0d got=%b want=%b", k, ob, ef);
         end
         if (k <= 72) begin
            n_cmp++;
            if (kt_t !== 7'(k - 1)) begin
               n_err++; $display("FAIL ignore kt_t cyc=%0d got=%0d want=%0d", k, kt_t, k - 1);
            end
         end
         if (k < 75) tick;
      end
      // held request accepted in the first idle cycle
      tick;
      start = 1'b0; n_blk = 4'd0;
      n_cmp++;
      if ({ready, kt_en, kt_t} !== {1'b0, 1'b1, 7'd0}) begin
         n_err++; $display("FAIL ignore accept got ready=%b kt_en=%b kt_t=%0d want 0/1/0", ready, kt_en, kt_t);
      end
      // accepted with n_blk=2: ready returns 147 cycles after accept
      for (int j = 2; j <= 147; j++) begin
         tick;
         n_cmp++;
         if (ready !== (j == 147)) begin
            n_err++; $display("FAIL ignore ready_ret j=%0d got=%b want=%b", j, ready, j == 147);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [5:0] ob;
      start = 1'b1; n_blk = 4'd2;
      tick;
      start = 1'b0; n_blk = 4'd0;
      for (int k = 1; k < 113; k++) tick;
      n_cmp++;
      if ({kt_t, rnd_valid, rnd, blk_idx} !== {7'd40, 1'b1, 6'd31, 4'd1}) begin
         n_err++; $display("FAIL rstmid pre got kt_t=%0d v=%b rnd=%0d blk=%0d want 40/1/31/1",
                           kt_t, rnd_valid, rnd, blk_idx);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ob = {ready, kt_en, rnd_valid, rnd_first, rnd_last, done};
         n_cmp++;
         if (ob !== 6'b100000) begin
            n_err++; $display("FAIL rstmid flags i=%0d got=%b want=100000", i, ob);
         end
         n_cmp++;
         if ({kt_t, rnd, blk_idx} !== 17'd0) begin
            n_err++; $display("FAIL rstmid values i=%0d got kt_t=%0d rnd=%0d blk=%0d want 0",
                              i, kt_t, rnd, blk_idx);
         end
         tick;
      end
   endtask

   task automatic test_reset_start;
      rst = 1'b1; start = 1'b1; n_blk = 4'd1;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_cmp++;
         if ({ready, kt_en} !== 2'b10) begin
            n_err++; $display("FAIL rststart hold i=%0d got=%b%b want=10", i, ready, kt_en);
         end
      end
      rst = 1'b0;
      tick;
      start = 1'b0;
      n_cmp++;
      if ({ready, kt_en, kt_t} !== {1'b0, 1'b1, 7'd0}) begin
         n_err++; $display("FAIL rststart accept got ready=%b kt_en=%b kt_t=%0d want 0/1/0", ready, kt_en, kt_t);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      tick;
   endtask

   initial begin
      for (int i = 0; i < 72; i++) begin
         rom[i] = (i >= 7 && i <= 70) ? K_TAB[i - 7] : 32'd0;
      end
      test_reset;
      test_single(4'd1, "single");
      test_single(4'd0, "nblk0");
      test_back_to_back;
      test_start_ignored;
      test_reset_mid;
      test_reset_start;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sha256_kt_seq.md
# sha256_kt_seq

Round sequencer directly upstream of the SHA-256 Kt constant BRAM. Accepts a start request for one or more 512-bit blocks and drives the BRAM read address `t` and read enable through the full 72-entry table per block: 7 leading zero slots, K[0..63], one trailing zero slot. Because the BRAM has a fixed 2-cycle read latency, the block also emits round-valid, round-index and block-boundary strobes delayed to line up with the `Kt` value at the BRAM output, so the compression core can consume `Kt` without its own bookkeeping.

## Interface
Parameters:
- N_SLOTS, 72: table entries walked per block.
- PRE_SLOTS, 7: leading zero slots before K[0].
- RD_LAT, 2: BRAM read latency, `kt_t` to `Kt`.

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted when `start & ready`.
- n_blk  in  4  blocks to process; sampled at accept; 0 is treated as 1.
- ready  out  1  high only in IDLE.
- kt_en  out  1  BRAM read enable.
- kt_t  out  7  BRAM read address, 0..71.
- kt_wr_en  out  1  BRAM dummy write-port enable; constant 0.
- kt_wr_addr  out  1  BRAM dummy write-port address; constant 0.
- rnd_valid  out  1  `Kt` at BRAM output is K[rnd].
- rnd  out  6  round index 0..63, valid with `rnd_valid`.
- rnd_first  out  1  rnd_valid and rnd==0.
- rnd_last  out  1  rnd_valid and rnd==63.
- blk_idx  out  4  index of the block being issued, valid with `rnd_valid`.
- done  out  1  one-cycle pulse with `rnd_last` of the final block.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: ready=1, kt_en=0, kt_t=0. On `start`: latch blocks_left = max(n_blk,1)-1 and blk=0, go to RUN.
- RUN: kt_en=1; kt_t counts 0..71, one step per cycle.
  - At kt_t=71: if blocks_left>0, decrement it, increment blk, and wrap kt_t to 0 on the next cycle. Blocks run back-to-back with no bubble.
  - Otherwise go to DRAIN.
- DRAIN: kt_en=0; hold for RD_LAT cycles so the last BRAM reads land, then go to IDLE.
- `start` is ignored outside IDLE; a new request is accepted no earlier than the first IDLE cycle.
- Issue-side tags: valid_i = kt_en & (7 ≤ kt_t ≤ 70), rnd_i = kt_t−7 (6-bit), blk_i = blk.
  - Tags go through a RD_LAT-deep register delay line to form rnd_valid, rnd, blk_idx, rnd_first, rnd_last.
  - done = rnd_last & (delayed blocks_left==0), also carried through the delay line.
- Zero slots (t 0..6 and 71) never assert rnd_valid.
- kt_wr_en and kt_wr_addr are tied low.
- Reset, at any time including mid-RUN: next cycle state=IDLE, ready=1, kt_en=0, kt_t=0, blk=0, and every delay-line stage cleared. Consequently rnd_valid, rnd, rnd_first, rnd_last, blk_idx and done are all 0. No stale strobe may appear after reset.
- `start` held high in the same cycle as `rst`: reset wins; the request is not accepted.

## Timing
- Accept in cycle C0, so kt_t=0 and kt_en=1 in C1; kt_t=k in C(1+k) for the first block.
- Block b starts at kt_t=0 in C(1+72b).
- Round r of block b: kt_t=r+7 in C(8+r+72b); rnd_valid/rnd=r in C(10+r+72b).
- rnd_valid high for 64 consecutive cycles per block, then low for 8 cycles between back-to-back blocks.
- Last kt_en cycle: C(72·N). done in C(73+72(N−1)). ready returns in C(72·N+3).
- Minimum start-to-start period for N blocks: 72·N+3 cycles.

## Test plan
- Single block (n_blk=1):
  - start in C0 -> kt_t sweeps 0..71 over C1..C72.
  - rnd_valid high over C10..C73 with rnd 0..63; rnd_first in C10, rnd_last and done in C73.
  - ready back high in C75; Kt sampled under rnd_valid equals K[0]=428a2f98 … K[63]=c67178f2.
- n_blk=3:
  - kt_t wraps 71→0 with no gap.
  - rnd_valid bursts start at C10, C82, C154 with blk_idx 0, 1, 2.
  - Single done pulse in C217.
- n_blk=0 -> behaves exactly as n_blk=1.
- start asserted during RUN and DRAIN -> ignored; ready stays 0 until IDLE; a request held into IDLE is accepted there.
- rst asserted at kt_t=40 of block 1 of 2 -> next cycle kt_en=0, ready=1, and all rnd_* and done outputs 0, remaining 0 for the following 3 cycles.
- Reset with start held high -> not accepted. Deassert rst with start still high -> accepted in the first post-reset cycle.
